// File: rtl/obuf_sched_pkg.sv
// Shared definitions for the output-buffer accumulation scheduler.
// Holds the scheduler state encoding and the default loop-nest dimensions.
package obuf_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    localparam int NUM_LOOPS_DEF = 5;
    localparam int LOOP_ID_W_DEF = 5;
    localparam int ITER_W_DEF    = 16;

endpackage

// File: rtl/accum_loop_cnt.sv
// One odometer stage of the accumulation loop nest.
// Counts carry_in events and wraps to zero once the count reaches iter.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_clear        force the count back to zero (takes priority over carry_in)
//   i_carry_in     advance this stage by one
//   i_iter         last count value of this loop (iterations minus one)
//   o_cnt          current count
//   o_at_zero      count is zero
//   o_at_max       count equals i_iter
//   o_carry_out    this stage wraps on the current carry_in
module accum_loop_cnt #(
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_carry_in,
    input  logic [ITER_W-1:0] i_iter,
    output logic [ITER_W-1:0] o_cnt,
    output logic              o_at_zero,
    output logic              o_at_max,
    output logic              o_carry_out
);

    logic [ITER_W-1:0] r_cnt;

    assign o_cnt       = r_cnt;
    assign o_at_zero   = (r_cnt == '0);
    assign o_at_max    = (r_cnt == i_iter);
    assign o_carry_out = i_carry_in & o_at_max;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_carry_in) begin
            r_cnt <= o_at_max ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/obuf_accum_sched.sv
// Accumulation scheduler for the output-buffer datapath.
// Models the layer as a loop nest of NUM_LOOPS counters (loop 0 innermost),
// advanced by tile completions. For each tile it tells the obuf read-mux
// whether to start from bias or accumulate onto obuf, and flags the final
// reduction pass so writeback can be enabled.
//
// state | meaning
// IDLE  | waiting for start; config writable; outputs sel/last held low
// RUN   | layer in progress; counting tile_done pulses
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_cfg_loop_iter_v     write strobe for one loop's iteration count
//   i_cfg_loop_index      target loop of the write
//   i_cfg_loop_iter       iterations minus one
//   i_cfg_red_mask_v      write strobe for reduction mask
//   i_cfg_red_mask        bit i set = loop i accumulates
//   i_start               begin a layer
//   i_tile_done           one innermost tile finished
//   o_obuf_bias_sel       1 = accumulate onto obuf, 0 = initialise from bias
//   o_last_accum          current tile is the final reduction pass
//   o_busy                layer in progress
//   o_done                one-cycle pulse after the final tile
//   o_cfg_err             one-cycle pulse for a rejected config write
module obuf_accum_sched
    import obuf_sched_pkg::*;
#(
    parameter int NUM_LOOPS = NUM_LOOPS_DEF,
    parameter int LOOP_ID_W = LOOP_ID_W_DEF,
    parameter int ITER_W    = ITER_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_cfg_loop_iter_v,
    input  logic [LOOP_ID_W-1:0] i_cfg_loop_index,
    input  logic [ITER_W-1:0]    i_cfg_loop_iter,
    input  logic                 i_cfg_red_mask_v,
    input  logic [NUM_LOOPS-1:0] i_cfg_red_mask,
    input  logic                 i_start,
    input  logic                 i_tile_done,
    output logic                 o_obuf_bias_sel,
    output logic                 o_last_accum,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_cfg_err
);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic [ITER_W-1:0]    r_iter [NUM_LOOPS];
    logic [NUM_LOOPS-1:0] r_red_mask;

    logic r_bias_sel;
    logic r_last_accum;
    logic r_done;
    logic r_cfg_err;

    logic [ITER_W-1:0]    w_cnt [NUM_LOOPS];
    logic [NUM_LOOPS-1:0] w_at_zero;
    logic [NUM_LOOPS-1:0] w_at_max;
    logic [NUM_LOOPS-1:0] w_zero_nxt;
    logic [NUM_LOOPS-1:0] w_max_nxt;
    logic [NUM_LOOPS:0]   w_carry;

    logic w_run;
    logic w_start_acc;
    logic w_final;
    logic w_clear;
    logic w_cfg_rej;
    logic w_iter_we;
    logic w_mask_we;
    logic w_red_zero_nxt;
    logic w_red_max_nxt;
    logic w_run_nxt;

    assign w_run       = (r_state == ST_RUN);
    assign w_start_acc = i_start & ~w_run;
    assign w_carry[0]  = i_tile_done & w_run;
    // The carry only leaves the outermost stage when every loop is at its max.
    assign w_final     = w_carry[NUM_LOOPS];
    assign w_clear     = w_start_acc | w_final;

    // A write is rejected while a layer runs or when it collides with a start.
    assign w_cfg_rej = (i_cfg_loop_iter_v | i_cfg_red_mask_v) & (w_run | i_start);
    assign w_iter_we = i_cfg_loop_iter_v & ~w_cfg_rej;
    assign w_mask_we = i_cfg_red_mask_v & ~w_cfg_rej;

    genvar g;
    generate
        for (g = 0; g < NUM_LOOPS; g++) begin : g_loop
            accum_loop_cnt #(
                .ITER_W(ITER_W)
            ) u_cnt (
                .clk        (clk),
                .reset      (reset),
                .i_clear    (w_clear),
                .i_carry_in (w_carry[g]),
                .i_iter     (r_iter[g]),
                .o_cnt      (w_cnt[g]),
                .o_at_zero  (w_at_zero[g]),
                .o_at_max   (w_at_max[g]),
                .o_carry_out(w_carry[g+1])
            );

            // Lookahead of each stage's flags one cycle ahead, so that the
            // select/last outputs can be registered without added latency.
            always_comb begin
                w_zero_nxt[g] = w_at_zero[g];
                w_max_nxt[g]  = w_at_max[g];
                if (w_clear) begin
                    w_zero_nxt[g] = 1'b1;
                    w_max_nxt[g]  = (r_iter[g] == '0);
                end else if (w_carry[g+1]) begin
                    w_zero_nxt[g] = 1'b1;
                    w_max_nxt[g]  = (r_iter[g] == '0);
                end else if (w_carry[g]) begin
                    w_zero_nxt[g] = 1'b0;
                    w_max_nxt[g]  = (ITER_W'(w_cnt[g] + 1'b1) == r_iter[g]);
                end
            end
        end
    endgenerate

    // Loops outside the reduction mask do not constrain either flag.
    assign w_red_zero_nxt = &(~r_red_mask | w_zero_nxt);
    assign w_red_max_nxt  = &(~r_red_mask | w_max_nxt);
    assign w_run_nxt      = (w_state_nxt == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_final) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bias_sel   <= 1'b0;
            r_last_accum <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bias_sel   <= w_run_nxt & ~w_red_zero_nxt;
            r_last_accum <= w_run_nxt & w_red_max_nxt;
            r_done       <= w_final;
            r_cfg_err    <= w_cfg_rej;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_red_mask <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                r_iter[i] <= '0;
            end
        end else begin
            if (w_mask_we) begin
                r_red_mask <= i_cfg_red_mask;
            end
            // Out-of-range indices match no entry and are dropped silently.
            for (int i = 0; i < NUM_LOOPS; i++) begin
                if (w_iter_we && (i_cfg_loop_index == LOOP_ID_W'(i))) begin
                    r_iter[i] <= i_cfg_loop_iter;
                end
            end
        end
    end

    assign o_obuf_bias_sel = r_bias_sel;
    assign o_last_accum    = r_last_accum;
    assign o_busy          = w_run;
    assign o_done          = r_done;
    assign o_cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_obuf_accum_sched.sv
module tb_obuf_accum_sched;

    logic        clk;
    logic        reset;
    logic        cfg_loop_iter_v;
    logic [4:0]  cfg_loop_index;
    logic [15:0] cfg_loop_iter;
    logic        cfg_red_mask_v;
    logic [4:0]  cfg_red_mask;
    logic        start;
    logic        tile_done;
    logic        obuf_bias_sel;
    logic        last_accum;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int n_pass;
    int n_total;

    obuf_accum_sched dut (
        .clk              (clk),
        .reset            (reset),
        .i_cfg_loop_iter_v(cfg_loop_iter_v),
        .i_cfg_loop_index (cfg_loop_index),
        .i_cfg_loop_iter  (cfg_loop_iter),
        .i_cfg_red_mask_v (cfg_red_mask_v),
        .i_cfg_red_mask   (cfg_red_mask),
        .i_start          (start),
        .i_tile_done      (tile_done),
        .o_obuf_bias_sel  (obuf_bias_sel),
        .o_last_accum     (last_accum),
        .o_busy           (busy),
        .o_done           (done),
        .o_cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic wr_iter(input logic [4:0] idx, input logic [15:0] val);
        cfg_loop_iter_v = 1'b1;
        cfg_loop_index  = idx;
        cfg_loop_iter   = val;
        tick();
        cfg_loop_iter_v = 1'b0;
        chk($sformatf("wr_iter%0d_err", idx), cfg_err, 1'b0);
    endtask

    task automatic wr_mask(input logic [4:0] m);
        cfg_red_mask_v = 1'b1;
        cfg_red_mask   = m;
        tick();
        cfg_red_mask_v = 1'b0;
        chk("wr_mask_err", cfg_err, 1'b0);
    endtask

    // es/el: expected select/last per tile, bit k = tile k+1.
    task automatic run_layer(input string name, input int n,
                             input logic [7:0] es, input logic [7:0] el,
                             input bit consec, input bit cfg_at_start,
                             input bit cfg_mid);
        start = 1'b1;
        if (cfg_at_start) begin
            cfg_loop_iter_v = 1'b1;
            cfg_loop_index  = 5'd0;
            cfg_loop_iter   = 16'd3;
        end
        tick();
        start = 1'b0;
        cfg_loop_iter_v = 1'b0;
        chk({name, "_start_busy"}, busy, 1'b1);
        chk({name, "_t1_sel"}, obuf_bias_sel, es[0]);
        chk({name, "_t1_last"}, last_accum, el[0]);
        chk({name, "_start_err"}, cfg_err, cfg_at_start);
        if (cfg_mid) begin
            start           = 1'b1;
            cfg_loop_iter_v = 1'b1;
            cfg_loop_index  = 5'd1;
            cfg_loop_iter   = 16'd5;
            tick();
            start           = 1'b0;
            cfg_loop_iter_v = 1'b0;
            chk({name, "_mid_err"}, cfg_err, 1'b1);
            chk({name, "_mid_busy"}, busy, 1'b1);
            chk({name, "_mid_sel"}, obuf_bias_sel, es[0]);
            chk({name, "_mid_last"}, last_accum, el[0]);
        end
        for (int k = 1; k <= n; k++) begin
            tile_done = 1'b1;
            tick();
            if (!consec || k == n) tile_done = 1'b0;
            if (k < n) begin
                chk($sformatf("%s_t%0d_sel", name, k + 1), obuf_bias_sel, es[k]);
                chk($sformatf("%s_t%0d_last", name, k + 1), last_accum, el[k]);
                chk($sformatf("%s_t%0d_busy", name, k + 1), busy, 1'b1);
                chk($sformatf("%s_t%0d_done", name, k + 1), done, 1'b0);
                chk($sformatf("%s_t%0d_err", name, k + 1), cfg_err, 1'b0);
                if (!consec) tick();
            end else begin
                chk({name, "_end_done"}, done, 1'b1);
                chk({name, "_end_busy"}, busy, 1'b0);
                chk({name, "_end_sel"}, obuf_bias_sel, 1'b0);
                chk({name, "_end_last"}, last_accum, 1'b0);
            end
        end
        tick();
        chk({name, "_done_clr"}, done, 1'b0);
        chk({name, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        reset           = 1'b1;
        cfg_loop_iter_v = 1'b0;
        cfg_loop_index  = '0;
        cfg_loop_iter   = '0;
        cfg_red_mask_v  = 1'b0;
        cfg_red_mask    = '0;
        start           = 1'b0;
        tile_done       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_sel", obuf_bias_sel, 1'b0);
        chk("rst_last", last_accum, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);

        // tile_done in IDLE has no effect
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        chk("idle_tile_busy", busy, 1'b0);
        chk("idle_tile_done", done, 1'b0);

        wr_iter(5'd0, 16'd1);
        wr_iter(5'd1, 16'd2);
        wr_mask(5'b00001);
        run_layer("m1", 6, 8'b101010, 8'b101010, 0, 0, 0);

        wr_mask(5'b00000);
        run_layer("m0", 6, 8'b000000, 8'b111111, 0, 0, 0);

        wr_mask(5'b00011);
        run_layer("m3", 6, 8'b111110, 8'b100000, 0, 0, 0);

        wr_iter(5'd0, 16'd3);
        wr_iter(5'd1, 16'd0);
        wr_mask(5'b00001);
        run_layer("b2b", 4, 8'b1110, 8'b1000, 1, 0, 0);

        // reset in the middle of a layer
        wr_iter(5'd0, 16'd1);
        wr_iter(5'd1, 16'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tile_done = 1'b1;
            tick();
            tile_done = 1'b0;
        end
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_sel", obuf_bias_sel, 1'b0);
        chk("midrst_last", last_accum, 1'b0);
        chk("midrst_done", done, 1'b0);
        tick();
        chk("midrst_done2", done, 1'b0);
        // cleared config: mask 0, all iters 0 -> single tile, (sel,last)=(0,1)
        run_layer("postrst", 1, 8'b0, 8'b1, 0, 0, 0);

        // rejected writes: same cycle as start, and during RUN
        wr_iter(5'd0, 16'd1);
        wr_iter(5'd1, 16'd2);
        wr_mask(5'b00001);
        run_layer("rej", 6, 8'b101010, 8'b101010, 0, 1, 1);

        // out-of-range index ignored without error; old config still in force
        wr_iter(5'd7, 16'd9);
        run_layer("oor", 6, 8'b101010, 8'b101010, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
